// File: rtl/ama_riscv_mem_arb_if.sv
// Bundle of the fetch port, load/store port and memory macro signals seen by
// the unified-memory arbiter. The arbiter takes the slave view; the core and
// memory side (or a bench) takes the master view.
interface ama_riscv_mem_arb_if #(
  parameter int MEM_AW = 12
);
  // fetch port
  logic              if_req_valid;
  logic              if_req_ready;
  logic [31:0]       if_req_addr;
  logic              if_rsp_valid;
  logic              if_rsp_ready;
  logic [31:0]       if_rsp_data;
  // load/store port
  logic              d_req_valid;
  logic              d_req_ready;
  logic [31:0]       d_req_addr;
  logic              d_req_we;
  logic [3:0]        d_req_wmask;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic              d_rsp_ready;
  logic [31:0]       d_rsp_data;
  // memory macro
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wmask, d_req_wdata, d_rsp_ready,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output d_req_valid, d_req_addr, d_req_we, d_req_wmask, d_req_wdata, d_rsp_ready,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ama_riscv_mem_arb.sv
// Arbiter/sequencer sharing one single-port unified memory between the fetch
// port and the load/store port. Data has priority, but fetch is forced after
// MAX_CONSEC back-to-back data grants while it is waiting. Reads have a fixed
// MEM_LAT latency; each port's read word is held in a one-entry buffer until
// that port consumes it.
module ama_riscv_mem_arb #(
  parameter int MEM_AW     = 12,
  parameter int MEM_LAT    = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst,
  ama_riscv_mem_arb_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);
  localparam logic [3:0] CONSEC_MAX = 4'(MAX_CONSEC);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;        // 1 = load/store port owns the read in flight
  logic [1:0]  lat_q, lat_d;
  logic [3:0]  consec_q, consec_d;
  logic        if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0] if_rsp_data_q, if_rsp_data_d;
  logic        d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0] d_rsp_data_q, d_rsp_data_d;

  logic f_elig, d_elig, f_win, d_win;

  // Byte-offset and aliased high address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_req_addr[1:0], bus.if_req_addr[31:MEM_AW+2],
                              bus.d_req_addr[1:0], bus.d_req_addr[31:MEM_AW+2]};

  // A port whose response buffer is still full cannot issue another read;
  // stores never produce a response so they bypass that restriction.
  assign f_elig = bus.if_req_valid && !if_rsp_valid_q;
  assign d_elig = bus.d_req_valid && (bus.d_req_we || !d_rsp_valid_q);

  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.d_rsp_valid  = d_rsp_valid_q;
  assign bus.d_rsp_data   = d_rsp_data_q;

  // Arbitration, memory strobes, read sequencing and response buffer updates.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    lat_d          = lat_q;
    consec_d       = consec_q;
    if_rsp_valid_d = if_rsp_valid_q;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_valid_d  = d_rsp_valid_q;
    d_rsp_data_d   = d_rsp_data_q;
    f_win          = 1'b0;
    d_win          = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 4'b0000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 32'h0;

    if (if_rsp_valid_q && bus.if_rsp_ready) if_rsp_valid_d = 1'b0;
    if (d_rsp_valid_q && bus.d_rsp_ready)   d_rsp_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst so nothing is granted while the block is being reset.
        if (!rst) begin
          f_win = f_elig && (!d_elig || consec_q == CONSEC_MAX);
          d_win = d_elig && !f_win;
        end
        if (d_win) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.d_req_we ? bus.d_req_wmask : 4'b0000;
          bus.mem_addr  = bus.d_req_addr[MEM_AW+1:2];
          bus.mem_wdata = bus.d_req_wdata;
          if (!bus.d_req_we) begin
            owner_d = 1'b1;
            lat_d   = LAT_INIT;
            state_d = WAIT;
          end
        end else if (f_win) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.if_req_addr[MEM_AW+1:2];
          owner_d      = 1'b0;
          lat_d        = LAT_INIT;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        // The owner's buffer was empty at grant and cannot refill meanwhile.
        if (lat_q == 2'd0) begin
          state_d = IDLE;
          if (owner_q) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = bus.mem_rdata;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = bus.mem_rdata;
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starvation guard: count data grants only while fetch is waiting.
    if (!f_elig || f_win) begin
      consec_d = 4'd0;
    end else if (d_win && consec_q != CONSEC_MAX) begin
      consec_d = consec_q + 4'd1;
    end

    bus.if_req_ready = f_win;
    bus.d_req_ready  = d_win;
  end

  // State and response buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      lat_q          <= 2'd0;
      consec_q       <= 4'd0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= 32'h0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= 32'h0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      lat_q          <= lat_d;
      consec_q       <= consec_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Bench for the unified-memory arbiter: directed steps on a MEM_LAT=1
// instance and a MEM_LAT=3 instance, then randomized traffic checked against
// a word-array memory model and per-port response queues.
module tb_ama_riscv_mem_arb;
  localparam int AW   = 12;
  localparam int MAXC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ama_riscv_mem_arb_if #(.MEM_AW(AW)) bus1 ();
  ama_riscv_mem_arb_if #(.MEM_AW(AW)) bus3 ();

  ama_riscv_mem_arb #(.MEM_AW(AW), .MEM_LAT(1), .MAX_CONSEC(MAXC)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  ama_riscv_mem_arb #(.MEM_AW(AW), .MEM_LAT(3), .MAX_CONSEC(MAXC)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  // memory for the latency-1 instance, with a backdoor preload port
  logic [31:0]   mem1 [0:(1<<AW)-1];
  logic [31:0]   rd1_q;
  logic          bk_we   = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [31:0]   bk_data = 32'h0;
  always @(posedge clk) begin
    rd1_q <= 32'h0BAD_F00D;
    if (bk_we) begin
      mem1[bk_addr] <= bk_data;
    end else if (bus1.mem_en) begin
      if (bus1.mem_we == 4'b0000) rd1_q <= mem1[bus1.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus1.mem_we[b]) mem1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
    end
  end
  assign bus1.mem_rdata = rd1_q;

  // latency-3 memory: read word is 0xA5000000 | word address
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    p3[0] <= bus3.mem_en ? (32'hA500_0000 | 32'(bus3.mem_addr)) : 32'h0BAD_F00D;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.mem_rdata = p3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[13:2] = {8'h02, 4'($urandom_range(0, 15))};
    return a;
  endfunction

  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] fq[$];
  logic [31:0] dq[$];
  logic [10:0] seq;
  logic        f_v, d_v, d_we, f_r, d_r;
  logic [31:0] f_a, d_a, d_wd, v;
  logic [3:0]  d_m;
  int          n, ng;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus1.if_req_valid = 0; bus1.if_req_addr = 0; bus1.if_rsp_ready = 0;
    bus1.d_req_valid = 0; bus1.d_req_addr = 0; bus1.d_req_we = 0;
    bus1.d_req_wmask = 0; bus1.d_req_wdata = 0; bus1.d_rsp_ready = 0;
    bus3.if_req_valid = 0; bus3.if_req_addr = 0; bus3.if_rsp_ready = 0;
    bus3.d_req_valid = 0; bus3.d_req_addr = 0; bus3.d_req_we = 0;
    bus3.d_req_wmask = 0; bus3.d_req_wdata = 0; bus3.d_rsp_ready = 0;

    // preload while in reset
    tick(); bk_we = 1; bk_addr = 12'h010; bk_data = 32'hDEADBEEF;
    tick(); bk_addr = 12'h011; bk_data = 32'h11112222;
    for (int i = 16'h20; i < 16'h30; i++) begin
      v = $urandom();
      ref_mem[i] = v;
      tick(); bk_addr = AW'(i); bk_data = v;
    end
    tick(); bk_we = 0;

    // reset state
    @(negedge clk);
    chk("rst_ctrl", 32'({bus1.if_req_ready, bus1.d_req_ready, bus1.if_rsp_valid,
                          bus1.d_rsp_valid, bus1.mem_en, bus1.mem_we}), 32'h0);
    chk("rst_if_data", bus1.if_rsp_data, 32'h0);
    chk("rst_d_data", bus1.d_rsp_data, 32'h0);
    chk("rst_mem_bus", 32'(bus1.mem_addr) | bus1.mem_wdata, 32'h0);
    tick(); rst = 0;

    // fetch 0x40 -> word 0x10
    tick(); bus1.if_req_valid = 1; bus1.if_req_addr = 32'h40; bus1.if_rsp_ready = 1;
    @(negedge clk);
    chk("f_ready_c0", 32'(bus1.if_req_ready), 32'h1);
    chk("f_mem_c0", 32'({bus1.mem_en, bus1.mem_we, bus1.mem_addr}), {15'h0, 1'b1, 4'h0, 12'h010});
    tick(); bus1.if_req_valid = 0;
    @(negedge clk);
    chk("f_wait_c1", 32'({bus1.if_rsp_valid, bus1.if_req_ready, bus1.mem_en}), 32'h0);
    @(negedge clk);
    chk("f_rsp_valid_c2", 32'(bus1.if_rsp_valid), 32'h1);
    chk("f_rsp_data_c2", bus1.if_rsp_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("f_rsp_consumed", 32'(bus1.if_rsp_valid), 32'h0);

    // store then load to 0x44
    tick(); bus1.d_req_valid = 1; bus1.d_req_we = 1; bus1.d_req_addr = 32'h44;
    bus1.d_req_wmask = 4'b0011; bus1.d_req_wdata = 32'h0000ABCD; bus1.d_rsp_ready = 1;
    @(negedge clk);
    chk("st_ready", 32'(bus1.d_req_ready), 32'h1);
    chk("st_mem", 32'({bus1.mem_en, bus1.mem_we, bus1.mem_addr}), {15'h0, 1'b1, 4'b0011, 12'h011});
    chk("st_wdata", bus1.mem_wdata, 32'h0000ABCD);
    tick(); bus1.d_req_we = 0;
    @(negedge clk);
    chk("ld_ready_c1", 32'(bus1.d_req_ready), 32'h1);
    chk("ld_mem_we", 32'(bus1.mem_we), 32'h0);
    tick(); bus1.d_req_valid = 0;
    @(negedge clk);
    chk("ld_wait", 32'(bus1.d_rsp_valid), 32'h0);
    @(negedge clk);
    chk("ld_rsp_valid", 32'(bus1.d_rsp_valid), 32'h1);
    chk("ld_rsp_data", bus1.d_rsp_data, 32'h1111ABCD);

    // starvation guard: back-to-back stores with fetch waiting. The guard
    // forces fetch after 4 data grants; the data grant made while the fetch
    // response is still buffered does not count toward the next 4.
    tick(); bus1.if_req_valid = 1; bus1.if_req_addr = 32'h48;
    bus1.d_req_valid = 1; bus1.d_req_we = 1; bus1.d_req_addr = 32'h100;
    bus1.d_req_wmask = 4'hF; bus1.d_req_wdata = 32'h5A5A5A5A;
    seq = '0; ng = 0; n = 0;
    while (ng < 11 && n < 40) begin
      @(negedge clk);
      if (bus1.d_req_ready || bus1.if_req_ready) begin
        seq = {seq[9:0], bus1.if_req_ready};
        ng++;
      end
      n++;
    end
    chk("grant_count", 32'(ng), 32'd11);
    chk("grant_seq", 32'(seq), 32'(11'b00001000001));
    tick(); bus1.if_req_valid = 0; bus1.d_req_valid = 0;
    repeat (4) tick();

    // load response held while fetch proceeds
    bus1.d_req_valid = 1; bus1.d_req_we = 0; bus1.d_req_addr = 32'h40; bus1.d_rsp_ready = 0;
    @(negedge clk);
    chk("hold_ld_grant", 32'(bus1.d_req_ready), 32'h1);
    tick(); bus1.d_req_addr = 32'h44; bus1.if_req_valid = 1; bus1.if_req_addr = 32'h44;
    n = 0;
    @(negedge clk);
    while (!bus1.d_rsp_valid && n < 8) begin @(negedge clk); n++; end
    chk("hold_rsp_valid", 32'(bus1.d_rsp_valid), 32'h1);
    chk("hold_fetch_wins", 32'({bus1.if_req_ready, bus1.d_req_ready}), 32'h2);
    repeat (6) begin
      @(negedge clk);
      chk("hold_no_ld", 32'({bus1.d_req_ready, bus1.d_rsp_valid}), 32'h1);
      chk("hold_data", bus1.d_rsp_data, 32'hDEADBEEF);
    end
    tick(); bus1.d_rsp_ready = 1;
    @(negedge clk);
    chk("consume_not_elig", 32'(bus1.d_req_ready), 32'h0);
    n = 0;
    while (!bus1.d_req_ready && n < 6) begin @(negedge clk); n++; end
    chk("hold_ld2_grant", 32'(bus1.d_req_ready), 32'h1);
    tick(); bus1.d_req_valid = 0; bus1.if_req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!bus1.d_rsp_valid && n < 8) begin @(negedge clk); n++; end
    chk("hold_ld2_data", bus1.d_rsp_data, 32'h1111ABCD);
    repeat (4) tick();

    // latency-3 instance: load 0x8, then both ports wait during WAIT
    bus3.d_req_valid = 1; bus3.d_req_addr = 32'h8; bus3.d_rsp_ready = 1; bus3.if_rsp_ready = 1;
    @(negedge clk);
    chk("l3_grant", 32'({bus3.d_req_ready, bus3.mem_en}), 32'h3);
    tick(); bus3.if_req_valid = 1; bus3.if_req_addr = 32'hC;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("l3_wait", 32'({bus3.d_req_ready, bus3.if_req_ready, bus3.mem_en, bus3.d_rsp_valid}), 32'h0);
    end
    @(negedge clk);
    chk("l3_rsp_valid", 32'(bus3.d_rsp_valid), 32'h1);
    chk("l3_rsp_data", bus3.d_rsp_data, 32'hA5000002);
    chk("l3_fetch_wins", 32'({bus3.if_req_ready, bus3.d_req_ready}), 32'h2);
    tick(); bus3.d_req_valid = 0; bus3.if_req_valid = 0;
    repeat (8) tick();

    // reset during WAIT drops the in-flight load
    bus1.d_req_valid = 1; bus1.d_req_we = 0; bus1.d_req_addr = 32'h40; bus1.d_rsp_ready = 1;
    @(negedge clk);
    chk("rw_grant", 32'(bus1.d_req_ready), 32'h1);
    tick(); bus1.d_req_valid = 0; rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("rw_outputs", 32'({bus1.if_req_ready, bus1.d_req_ready, bus1.if_rsp_valid,
                            bus1.d_rsp_valid, bus1.mem_en, bus1.mem_we}), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rw_no_rsp", 32'(bus1.d_rsp_valid), 32'h0);
    end
    tick(); bus1.if_req_valid = 1; bus1.if_req_addr = 32'h44; bus1.if_rsp_ready = 1;
    @(negedge clk);
    chk("rw_fetch_grant", 32'(bus1.if_req_ready), 32'h1);
    tick(); bus1.if_req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!bus1.if_rsp_valid && n < 8) begin @(negedge clk); n++; end
    chk("rw_fetch_data", bus1.if_rsp_data, 32'h1111ABCD);
    repeat (3) tick();

    // randomized traffic against the memory model
    f_v = 0; d_v = 0; d_we = 0; f_r = 1; d_r = 1;
    f_a = 0; d_a = 0; d_wd = 0; d_m = 0;
    bus1.if_rsp_ready = 1; bus1.d_rsp_ready = 1;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(negedge clk);
      chk("rnd_one_grant", 32'(bus1.if_req_ready & bus1.d_req_ready), 32'h0);
      if (bus1.d_req_ready) begin
        chk("rnd_d_addr", 32'(bus1.mem_addr), 32'(d_a[13:2]));
        if (d_we) begin
          chk("rnd_st_we", 32'(bus1.mem_we), 32'(d_m));
          chk("rnd_st_wdata", bus1.mem_wdata, d_wd);
          for (int b = 0; b < 4; b++)
            if (d_m[b]) ref_mem[d_a[13:2]][8*b +: 8] = d_wd[8*b +: 8];
        end else begin
          dq.push_back(ref_mem[d_a[13:2]]);
        end
      end
      if (bus1.if_req_ready) begin
        chk("rnd_f_addr", 32'({bus1.mem_we, bus1.mem_addr}), 32'(f_a[13:2]));
        fq.push_back(ref_mem[f_a[13:2]]);
      end
      if (bus1.if_rsp_valid) begin
        if (fq.size() == 0) chk("rnd_if_spurious", 32'(bus1.if_rsp_valid), 32'h0);
        else begin
          chk("rnd_if_data", bus1.if_rsp_data, fq[0]);
          if (f_r) void'(fq.pop_front());
        end
      end
      if (bus1.d_rsp_valid) begin
        if (dq.size() == 0) chk("rnd_d_spurious", 32'(bus1.d_rsp_valid), 32'h0);
        else begin
          chk("rnd_d_data", bus1.d_rsp_data, dq[0]);
          if (d_r) void'(dq.pop_front());
        end
      end
      if (cyc < 420) begin
        if (!f_v || bus1.if_req_ready) begin
          f_v = ($urandom_range(0, 3) != 0); f_a = rand_addr();
        end
        if (!d_v || bus1.d_req_ready) begin
          d_v = ($urandom_range(0, 3) != 0); d_a = rand_addr();
          d_we = ($urandom_range(0, 2) == 0); d_m = 4'($urandom()); d_wd = $urandom();
        end
        f_r = ($urandom_range(0, 3) != 0);
        d_r = ($urandom_range(0, 3) != 0);
      end else begin
        f_v = 0; d_v = 0; f_r = 1; d_r = 1;
      end
      tick();
      bus1.if_req_valid = f_v; bus1.if_req_addr = f_a; bus1.if_rsp_ready = f_r;
      bus1.d_req_valid = d_v; bus1.d_req_addr = d_a; bus1.d_req_we = d_we;
      bus1.d_req_wmask = d_m; bus1.d_req_wdata = d_wd; bus1.d_rsp_ready = d_r;
    end
    chk("rnd_if_drained", 32'(fq.size()), 32'h0);
    chk("rnd_d_drained", 32'(dq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
